// File: rtl/mac_pkg.sv
// Shared widths and signed types for the CNN dot-product MAC array.
package mac_pkg;

  localparam int unsigned DefNumMacs = 4;
  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefAccW    = 32;
  localparam int unsigned DefDotW    = 36;

  typedef logic signed [DefDataW-1:0] operand_t;
  typedef logic signed [DefAccW-1:0]  acc_t;
  typedef logic signed [DefDotW-1:0]  dot_t;

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; wraps modulo 2^ACC_W on overflow.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  // Full-width signed product, then clear > enable > hold.
  always_comb begin
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_array.sv
// Parallel signed MAC lanes plus a combinational sum of all lane accumulators.
// DOT_W must be at least ACC_W + clog2(NUM_MACS) so the sum cannot overflow.
module mac_array
  import mac_pkg::*;
#(
  parameter int unsigned NUM_MACS = DefNumMacs,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned DOT_W    = DefDotW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] a [NUM_MACS],
  input  logic signed [DATA_W-1:0] b [NUM_MACS],
  output logic                     valid_out,
  output logic signed [ACC_W-1:0]  acc_out [NUM_MACS],
  output logic signed [DOT_W-1:0]  dot_out
);

  logic                    valid_d, valid_q;
  logic signed [ACC_W-1:0] acc [NUM_MACS];
  logic signed [DOT_W-1:0] dot_sum;

  // start wins over a same-cycle beat, so that beat never reports as accepted.
  always_comb begin
    valid_d = valid_in & ~start;
  end

  // Beat-accepted flag, aligned with the updated accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .en    (valid_in),
      .a     (a[i]),
      .b     (b[i]),
      .acc   (acc[i])
    );
  end

  // Sign-extend each lane and sum; synthesis balances the chain into a tree.
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < NUM_MACS; i++) begin
      dot_sum = dot_sum + DOT_W'(acc[i]);
    end
  end

  assign acc_out   = acc;
  assign dot_out   = dot_sum;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array with a reference model and an output scoreboard.
module tb_mac_array;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, valid_in;
  logic signed [7:0]  a [N];
  logic signed [7:0]  b [N];
  logic               valid_out;
  logic signed [31:0] acc_out [N];
  logic signed [35:0] dot_out;

  // Narrow-accumulator instance so the wrap case is reachable in a few beats.
  logic               w_start, w_valid;
  logic signed [7:0]  w_a [N];
  logic signed [7:0]  w_b [N];
  logic               w_valid_out;
  logic signed [15:0] w_acc_out [N];
  logic signed [17:0] w_dot_out;

  mac_array #(
    .NUM_MACS (N),
    .DATA_W   (8),
    .ACC_W    (32),
    .DOT_W    (36)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .acc_out   (acc_out),
    .dot_out   (dot_out)
  );

  mac_array #(
    .NUM_MACS (N),
    .DATA_W   (8),
    .ACC_W    (16),
    .DOT_W    (18)
  ) dut_w (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .valid_in  (w_valid),
    .a         (w_a),
    .b         (w_b),
    .valid_out (w_valid_out),
    .acc_out   (w_acc_out),
    .dot_out   (w_dot_out)
  );

  typedef struct packed {
    logic [N*32-1:0] accs;
    logic [35:0]     dot;
  } exp_t;

  exp_t               sb [$];
  logic signed [31:0] m_acc [N];
  logic               m_valid;
  int                 tests = 0;
  int                 fails = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic signed [35:0] model_dot();
    logic signed [35:0] s = '0;
    for (int i = 0; i < N; i++) s = s + 36'(m_acc[i]);
    return s;
  endfunction

  task automatic set_ab(input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3);
    a[0] = 8'(a0); a[1] = 8'(a1); a[2] = 8'(a2); a[3] = 8'(a3);
    b[0] = 8'(b0); b[1] = 8'(b1); b[2] = 8'(b2); b[3] = 8'(b3);
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      a[i] = 8'($urandom_range(0, 255));
      b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Drive one cycle, advance the model, then check model and scoreboard.
  task automatic step(input logic r, input logic s, input logic v);
    exp_t e;
    rst = r; start = s; valid_in = v;
    if (r || s) begin
      for (int i = 0; i < N; i++) m_acc[i] = '0;
      m_valid = 1'b0;
    end else if (v) begin
      for (int i = 0; i < N; i++) m_acc[i] = m_acc[i] + 32'(a[i]) * 32'(b[i]);
      m_valid = 1'b1;
      for (int i = 0; i < N; i++) e.accs[i*32 +: 32] = m_acc[i];
      e.dot = model_dot();
      sb.push_back(e);
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid_out", valid_out, m_valid);
    for (int i = 0; i < N; i++) chk($sformatf("acc_out[%0d]", i), acc_out[i], m_acc[i]);
    chk("dot_out", dot_out, model_dot());
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_dot", dot_out, $signed(e.dot));
        for (int i = 0; i < N; i++)
          chk($sformatf("sb_acc[%0d]", i), acc_out[i], $signed(e.accs[i*32 +: 32]));
      end
    end
  endtask

  initial begin
    int vcount;
    w_start = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_a[i] = '0; w_b[i] = '0; m_acc[i] = '0;
    end
    m_valid = 1'b0;

    // 1. Reset with a live beat on the inputs.
    set_rand();
    step(1'b1, 1'b0, 1'b1);
    chk("rst_dot", dot_out, 0);
    chk("rst_valid", valid_out, 0);

    // 2. Two-beat window.
    vcount = 0;
    set_rand();
    step(1'b0, 1'b1, 1'b0);
    set_ab(1, 2, 3, 4, 2, 3, 4, 5);
    step(1'b0, 1'b0, 1'b1);
    vcount += int'(valid_out);
    chk("b1_dot", dot_out, 40);
    chk("b1_acc0", acc_out[0], 2);
    chk("b1_acc3", acc_out[3], 20);
    set_ab(-1, 1, 0, -2, 2, 1, 5, 3);
    step(1'b0, 1'b0, 1'b1);
    vcount += int'(valid_out);
    chk("b2_acc0", acc_out[0], 0);
    chk("b2_acc1", acc_out[1], 7);
    chk("b2_acc2", acc_out[2], 12);
    chk("b2_acc3", acc_out[3], 14);
    chk("b2_dot", dot_out, 33);

    // 3. Freeze with changing operands.
    for (int k = 0; k < 3; k++) begin
      set_rand();
      step(1'b0, 1'b0, 1'b0);
      vcount += int'(valid_out);
      chk("freeze_dot", dot_out, 33);
    end
    chk("valid_count", vcount, 2);

    // 4. start collides with a beat: beat discarded.
    set_ab(5, 5, 5, 5, 5, 5, 5, 5);
    step(1'b0, 1'b1, 1'b1);
    chk("coll_dot", dot_out, 0);
    chk("coll_acc2", acc_out[2], 0);
    chk("coll_valid", valid_out, 0);

    // 5. Extreme operands.
    set_ab(-128, -128, -128, -128, -128, -128, -128, -128);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
    chk("ext_acc1", acc_out[1], 65536);
    chk("ext_dot", dot_out, 262144);
    set_ab(127, 0, 0, 0, -128, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("ext_acc0", acc_out[0], 49280);
    chk("ext_dot2", dot_out, 245888);

    // Reset mid-window discards partial sums.
    set_rand();
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_dot", dot_out, 0);

    // 6. Wrap on the 16-bit instance: 16384 + 16384 + 16129 mod 2^16.
    set_ab(0, 0, 0, 0, 0, 0, 0, 0);
    w_a[0] = -8'sd128; w_b[0] = -8'sd128; w_valid = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_acc_1", w_acc_out[0], 16384);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_acc_2", w_acc_out[0], -32768);
    w_a[0] = 8'sd127; w_b[0] = 8'sd127;
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_acc_3", w_acc_out[0], -16639);
    chk("wrap_dot", w_dot_out, -16639);
    chk("wrap_valid", w_valid_out, 1);
    w_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_hold", w_acc_out[0], -16639);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
